// File: rtl/interval_pkg.sv
// Shared constants, payload types and FP format helpers for the interval decode path.
package interval_pkg;

   typedef enum logic [2:0] {
      FP32    = 3'd0,
      FP64    = 3'd1,
      FP16    = 3'd2,
      FP8     = 3'd3,
      FP16ALT = 3'd4
   } fp_format_e;

   localparam int NUM_INTERVALS = 8;
   localparam int IDX_W_DEF     = $clog2(NUM_INTERVALS);
   localparam int WIDTH_DEF     = 16;

   localparam logic [15:0] FP16_ZERO = 16'h0000;
   localparam logic [15:0] FP16_QNAN = 16'h7E00;

   typedef struct packed {
      logic [IDX_W_DEF-1:0] idx;
      logic                 err;
   } s1_payload_t;

   typedef struct packed {
      logic [WIDTH_DEF-1:0] value;
      logic [IDX_W_DEF-1:0] idx;
      logic                 err;
   } s2_payload_t;

   function automatic int fp_width(input fp_format_e fmt);
      case (fmt)
         FP32:    return 32;
         FP64:    return 64;
         FP16:    return 16;
         FP8:     return 8;
         FP16ALT: return 16;
         default: return 16;
      endcase
   endfunction

   // Canonical quiet NaN, right-aligned in 64 bits.
   function automatic logic [63:0] fp_qnan(input fp_format_e fmt);
      case (fmt)
         FP32:    return 64'h0000_0000_7FC0_0000;
         FP64:    return 64'h7FF8_0000_0000_0000;
         FP16:    return {48'h0, FP16_QNAN};
         FP8:     return 64'h0000_0000_0000_007E;
         FP16ALT: return 64'h0000_0000_0000_7FC0;
         default: return {48'h0, FP16_QNAN};
      endcase
   endfunction

endpackage

// File: rtl/interval_onehot_enc.sv
// One-hot code to index encoder; flags codes that are all-zero or have several bits set.
module interval_onehot_enc #(
   parameter int NUM   = 8,
   parameter int IDX_W = $clog2(NUM)
) (
   input  logic [NUM-1:0]   code_i,
   output logic [IDX_W-1:0] index_o,
   output logic             err_o
);

   // Descending scan so the lowest set bit wins on malformed codes.
   always_comb begin
      index_o = '0;
      for (int i = NUM - 1; i >= 0; i--) begin
         if (code_i[i]) index_o = IDX_W'(i);
      end
   end

   assign err_o = (code_i == '0) || ((code_i & (code_i - 1'b1)) != '0);

endmodule

// File: rtl/interval_decode.sv
// Two-stage valid/ready decoder: one-hot interval code -> programmable representative value.
module interval_decode
   import interval_pkg::*;
#(
   parameter int         NUM      = NUM_INTERVALS,
   parameter fp_format_e FpFormat = FP16,
   parameter int         WIDTH    = fp_width(FpFormat),
   parameter int         IDX_W    = $clog2(NUM),
   parameter int         CNT_W    = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cfg_we_i,
   input  logic [IDX_W-1:0] cfg_addr_i,
   input  logic [WIDTH-1:0] cfg_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [NUM-1:0]   interval_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] value_o,
   output logic [IDX_W-1:0] index_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   localparam logic [WIDTH-1:0] QNAN = WIDTH'(fp_qnan(FpFormat));

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             err;
   } s1_pl_t;

   typedef struct packed {
      logic [WIDTH-1:0] value;
      logic [IDX_W-1:0] idx;
      logic             err;
   } s2_pl_t;

   logic [WIDTH-1:0] r_table [NUM];
   s1_pl_t           r_s1;
   s2_pl_t           r_s2;
   logic             r_s1_valid;
   logic             r_s2_valid;
   logic [CNT_W-1:0] r_err_cnt;

   logic             w_s1_ready;
   logic             w_s2_ready;
   logic             w_accept;
   logic             w_xfer;
   logic             w_cfg_hit;
   logic [IDX_W-1:0] w_enc_idx;
   logic             w_enc_err;

   interval_onehot_enc #(
      .NUM   (NUM),
      .IDX_W (IDX_W)
   ) u_enc (
      .code_i  (interval_i),
      .index_o (w_enc_idx),
      .err_o   (w_enc_err)
   );

   assign w_s2_ready = !r_s2_valid || out_ready_i;
   assign w_s1_ready = !r_s1_valid || w_s2_ready;
   assign w_accept   = in_valid_i && w_s1_ready;
   assign w_xfer     = r_s1_valid && w_s2_ready;
   // Out-of-range addresses only exist when NUM is not a power of two.
   assign w_cfg_hit  = cfg_we_i && (int'(cfg_addr_i) < NUM);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_s1_valid <= 1'b0;
         r_s1       <= '0;
      end else begin
         if (w_s1_ready) r_s1_valid <= in_valid_i;
         if (w_accept) begin
            r_s1.idx <= w_enc_idx;
            r_s1.err <= w_enc_err;
         end
      end
   end

   // Table read happens here, so a same-cycle write is seen only by later transfers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_s2_valid <= 1'b0;
         r_s2       <= '0;
      end else begin
         if (w_s2_ready) r_s2_valid <= r_s1_valid;
         if (w_xfer) begin
            r_s2.value <= r_s1.err ? QNAN : r_table[r_s1.idx];
            r_s2.idx   <= r_s1.idx;
            r_s2.err   <= r_s1.err;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM; i++) r_table[i] <= '0;
      end else if (w_cfg_hit) begin
         r_table[cfg_addr_i] <= cfg_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err_cnt <= '0;
      end else if (w_xfer && r_s1.err && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign in_ready_o  = w_s1_ready;
   assign out_valid_o = r_s2_valid;
   assign value_o     = r_s2.value;
   assign index_o     = r_s2.idx;
   assign err_o       = r_s2.err;
   assign err_cnt_o   = r_err_cnt;

endmodule

// File: doc/interval_decode.md
Name: interval_decode

Overview:
- Inverse of the interval classifier: accepts a one-hot interval code and returns the FP16 representative value programmed for that interval.
- Used to reconstruct approximate activations from interval codes in the DAL datapath.
- Two-stage valid/ready pipeline; the representative table is runtime-programmable through a simple write port.
- Also flags malformed codes and counts them.

Parameters:
- NUM, 8, number of intervals (one-hot code width); must be ≥2.
- FpFormat, fpnew_pkg::fp_format_e'(2) (FP16), value format.
- WIDTH, fpnew_pkg::fp_width(FpFormat) = 16, value width.
- IDX_W, $clog2(NUM) = 3, interval index width.
- CNT_W, 16, error counter width.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_we_i  in  1  table write strobe.
- cfg_addr_i  in  IDX_W  table entry to write.
- cfg_data_i  in  WIDTH  representative value to store.
- in_valid_i  in  1  input code valid.
- in_ready_o  out  1  block accepts the input code.
- interval_i  in  NUM  one-hot interval code; bit i means interval i.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  downstream accepts the output.
- value_o  out  WIDTH  representative value.
- index_o  out  IDX_W  decoded interval index.
- err_o  out  1  code was not one-hot.
- err_cnt_o  out  CNT_W  saturating count of malformed codes accepted.

Behaviour:
- Reset values:
  - All table entries 16'h0000 (+0.0).
  - Stage valids 0, so out_valid_o = 0.
  - value_o 0, index_o 0, err_o 0, err_cnt_o 0.
  - Reset is honoured mid-transfer: in-flight items are discarded and never emitted.
- Stage S1, on accept when in_valid_i & in_ready_o:
  - Register the encoded index and the error flag.
  - err = 1 when popcount(interval_i) != 1, i.e. the code is all-zero or has more than one bit set.
  - On error, the index is the lowest set bit, or 0 if the code is all-zero.
- Stage S2, on the S1→S2 transfer:
  - Register the table entry for the S1 index into value_o.
  - If err is set, load the canonical qNaN 16'h7E00 instead.
- Latency: an input accepted in cycle N appears with out_valid_o = 1 in cycle N+2. Sustained throughput is 1 item/cycle.
- Handshake:
  - s2_ready = !s2_valid | out_ready_i.
  - s1_ready = !s1_valid | s2_ready.
  - in_ready_o = s1_ready.
  - Ready is combinational through both stages; no combinational valid→ready path.
- Backpressure:
  - While out_valid_o & !out_ready_i, value_o, index_o and err_o hold stable.
  - The S1 item is held and no data is lost or duplicated.
- Table writes:
  - A write in cycle N is visible to S1→S2 transfers from cycle N+1.
  - A transfer in cycle N itself reads the old entry.
  - Writes never stall the stream.
  - When NUM is not a power of two, writes with cfg_addr_i ≥ NUM are ignored.
- err_cnt_o:
  - Increments by 1 when an erroneous item transfers S1→S2.
  - Saturates at 2^CNT_W−1; no wrap.
- Simultaneous events:
  - A new input is accepted and the output is consumed in the same cycle: both occur, no bubble.
  - A write to the entry being read in the same cycle: the old value is emitted.

Decomposition:
- interval_pkg holds:
  - the NUM_INTERVALS default;
  - the FP16 constants FP16_ZERO = 16'h0000 and FP16_QNAN = 16'h7E00;
  - typedef s1_payload_t {idx, err};
  - typedef s2_payload_t {value, idx, err}.
- One sub-module, interval_onehot_enc: combinational NUM→{index, err} encoder, shared with future classifier-side checks.

Test Plan:
- Reset, then table[i] = i×0.5 in FP16 (entry 3 = 16'h3E00). Stream codes 8'h01, 8'h02, 8'h08 with out_ready_i = 1 → outputs 16'h0000, 16'h3800, 16'h3E00 on consecutive cycles; first output at +2 cycles; index_o = 0, 1, 3.
- Send codes 8'h00, then 8'h14 → value_o = 16'h7E00, err_o = 1, index_o = 0 then 2; err_cnt_o ends at 2.
- Hold out_ready_i = 0 for 5 cycles while sending 4 codes → in_ready_o drops after 2 accepts, value_o is stable. On release, exactly the 4 values emerge in order.
- Write table[5] = 16'h4000 in the same cycle code 8'h20 transfers S1→S2 → output 16'h0000 (old). The next 8'h20 outputs 16'h4000.
- Force err_cnt_o near max (CNT_W = 4 build) and send 20 bad codes → err_cnt_o saturates at 15.
- Assert rst_ni low with both stages valid → out_valid_o = 0 immediately. After release, no stale item is output and the table reads 0.
